flit_sink_drain_ctrl: RTL
=========================

// Module: flit_sink_drain_ctrl
// PURPOSE
//  Drain scheduler for a terminal flit sink: tracks per-VC flit occupancy of the sink flit buffer and selects one VC
//  per permitted cycle to pop. The pop rate is set by a deterministic rate accumulator, and VCs are shared round-robin.
//  Each pop produces a registered credit in the standard credit flow-control format, returned upstream.
//  Sits between rtr_channel_input/rtr_flit_buffer and the upstream router's credit input.
// PARAMETERS
//  num_vcs            8    number of VCs; vc_idx_width = clogb(num_vcs)
//  buffer_size        64   total sink buffer flits; buffer_size_per_vc = buffer_size/num_vcs
//  consume_rate       50   drain rate, percent of cycles (1..100)
//  reset_type         `RESET_TYPE_SYNC   fixed; sync reset only
// PORTS
//  clk            in   1                  clock
//  reset          in   1                  synchronous, active-high reset
//  push_valid     in   1                  flit written into sink buffer this cycle
//  push_sel_ivc   in   num_vcs            one-hot VC of pushed flit
//  pop_tail_ivc   in   num_vcs            per VC: flit at buffer head is a tail (used only with macro)
//  pop_valid      out  1                  pop request to buffer (combinational)
//  pop_sel_ivc    out  num_vcs            one-hot VC popped (all-zero when !pop_valid)
//  flow_ctrl      out  1+vc_idx_width     registered credit: {valid, vc_idx}
//  error          out  1                  sticky overflow/underflow flag
// BEHAVIOUR
//  Reset (sync, active-high): occ[v]=0, acc=0, rr_ptr=0, flow_ctrl=0, error=0, lock cleared; pending credit dropped.
//  Rate accumulator acc (7 bits, 0..99), updated every cycle:
//   - permit = (acc+consume_rate >= 100).
//   - acc <= permit ? acc+consume_rate-100 : acc+consume_rate.
//   - The permit is independent of requests; an unused permit is lost, not banked.
//   - Example, rate 50: permit on cycles 2,4,6... after reset; rate 100: permit every cycle.
//  Occupancy occ[v] (clogb(buffer_size_per_vc+1) bits):
//   - +1 on push to v, -1 on pop of v; push and pop of the same v in one cycle leave it unchanged.
//  Requests: req[v] = (occ[v]!=0). A flit pushed in cycle N is poppable no earlier than cycle N+1 (no bypass).
//  Grant: pop_valid = permit & |req.
//   - pop_sel_ivc = first req at or after rr_ptr, wrapping num_vcs-1 -> 0.
//   - On a pop, rr_ptr <= (granted_idx+1) mod num_vcs; rr_ptr holds otherwise.
//  Credit: the cycle after a pop of v, flow_ctrl = {1'b1, v}; otherwise flow_ctrl = 0. Fixed latency 1, one credit max per cycle.
//  Errors (error set, sticky until reset):
//   - push to v with occ[v]==buffer_size_per_vc and no same-cycle pop of v: occ saturates.
//   - non-one-hot push_sel_ivc while push_valid.
//  Underflow cannot occur by construction; a pop is granted only when occ!=0.
// CONFIGURATION
//  FLIT_SINK_DRAIN_PKT_ATOMIC_EN:
//   - Defined: packet-atomic drain. After a pop of v with pop_tail_ivc[v]==0, the arbiter locks on v.
//   - While locked, pop_valid = permit & req[v] and only v is granted; other VCs wait even if v is empty.
//   - The lock releases on the pop where pop_tail_ivc[v]==1. rr_ptr advances only on that release pop.
//   - Undefined: flit-level round-robin as above; pop_tail_ivc is ignored.
// TESTING
//  Reset, then 3 pushes to VC2 at rate 100 -> pops on VC2 in 3 consecutive cycles starting the cycle after the first
//   push; flow_ctrl={1,2} in the 3 cycles after each pop; occ[2] returns to 0.
//  VC0,VC3,VC5 each hold 2 flits, rate 100 -> pop order 0,3,5,0,3,5; rr_ptr wrap verified.
//  Rate 25, VC1 holds 8 flits -> exactly one pop every 4th cycle (cycles 4,8,...); no credits in between.
//  buffer_size_per_vc (8) pushes to VC4 at rate 0-equivalent (no permits, pop blocked), then a 9th push -> error=1,
//   occ[4]=8; error stays 1 until reset.
//  Same-cycle push and pop on VC6 with occ=1 -> occ stays 1; assert reset mid-stream -> next cycle flow_ctrl=0,
//   pop_valid=0, all occ=0.
//  With FLIT_SINK_DRAIN_PKT_ATOMIC_EN: VC0 holds a 3-flit packet, VC1 holds 1 flit, rate 100 -> pops 0,0,0,1;
//   without the macro -> pops 0,1,0,0.

Source files
------------

// File: rtl/flit_sink_drain_ctrl.sv
`default_nettype none
// ============================================================================
// flit_sink_drain_ctrl : rate-limited round-robin drain scheduler for a
// terminal flit sink, returning one registered credit per pop.
// Optional FLIT_SINK_DRAIN_PKT_ATOMIC_EN: packet-atomic drain (lock on VC).
// Revision: 1.0
// ============================================================================
module flit_sink_drain_ctrl #(
   parameter int NUM_VCS        = 8,
   parameter int BUFFER_SIZE    = 64,
   parameter int CONSUME_RATE   = 50,
   localparam int VC_IDX_WIDTH  = $clog2(NUM_VCS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_valid,
   input  logic [NUM_VCS-1:0]      push_sel_ivc,
   input  logic [NUM_VCS-1:0]      pop_tail_ivc,
   output logic                    pop_valid,
   output logic [NUM_VCS-1:0]      pop_sel_ivc,
   output logic [VC_IDX_WIDTH:0]   flow_ctrl,
   output logic                    error
);

   localparam int PER_VC = BUFFER_SIZE / NUM_VCS;
   localparam int OCC_W  = $clog2(PER_VC + 1);

   localparam logic [OCC_W-1:0]        C_OCC_MAX = OCC_W'(PER_VC);
   localparam logic [VC_IDX_WIDTH:0]   C_NUM_VCS = (VC_IDX_WIDTH+1)'(NUM_VCS);
   localparam logic [VC_IDX_WIDTH-1:0] C_LAST_VC = VC_IDX_WIDTH'(NUM_VCS - 1);
   localparam logic [7:0]              C_RATE    = 8'(CONSUME_RATE);

   logic [6:0]              acc_q, acc_d;
   logic [OCC_W-1:0]        occ_q [NUM_VCS];
   logic [OCC_W-1:0]        occ_d [NUM_VCS];
   logic [VC_IDX_WIDTH-1:0] rr_q, rr_d;
   logic [VC_IDX_WIDTH:0]   flow_ctrl_q, flow_ctrl_d;
   logic                    error_q, error_d;

   logic [7:0]              w_acc_sum;
   logic                    w_permit;
   logic [NUM_VCS-1:0]      w_req;
   logic [2*NUM_VCS-1:0]    w_req_dbl;
   logic [NUM_VCS-1:0]      w_req_rot;
   logic                    w_rr_found;
   logic [VC_IDX_WIDTH-1:0] w_rr_off;
   logic [VC_IDX_WIDTH:0]   w_rr_sum;
   logic [VC_IDX_WIDTH-1:0] w_rr_idx;
   logic                    w_gnt_found;
   logic [VC_IDX_WIDTH-1:0] w_gnt_idx;
   logic [VC_IDX_WIDTH-1:0] w_gnt_next;
   logic [NUM_VCS-1:0]      w_gnt_onehot;
   logic                    w_push_onehot;
   logic [NUM_VCS-1:0]      w_inc;
   logic [NUM_VCS-1:0]      w_dec;

   // ------------------------------------------------------------------------
   // Rate accumulator: permit whenever the running sum crosses 100
   // ------------------------------------------------------------------------
   assign w_acc_sum = {1'b0, acc_q} + C_RATE;
   assign w_permit  = (w_acc_sum >= 8'd100);
   assign acc_d     = w_permit ? 7'(w_acc_sum - 8'd100) : 7'(w_acc_sum);

   always_comb begin
      w_req = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         w_req[v] = (occ_q[v] != '0);
      end
   end

   // ------------------------------------------------------------------------
   // Round-robin search: rotate requests so rr_q lands on bit 0, take lowest
   // ------------------------------------------------------------------------
   assign w_req_dbl = {w_req, w_req};
   assign w_req_rot = NUM_VCS'(w_req_dbl >> rr_q);

   always_comb begin
      w_rr_found = 1'b0;
      w_rr_off   = '0;
      for (int i = NUM_VCS - 1; i >= 0; i--) begin
         if (w_req_rot[i]) begin
            w_rr_found = 1'b1;
            w_rr_off   = VC_IDX_WIDTH'(i);
         end
      end
   end

   assign w_rr_sum = {1'b0, rr_q} + {1'b0, w_rr_off};
   assign w_rr_idx = (w_rr_sum >= C_NUM_VCS) ? VC_IDX_WIDTH'(w_rr_sum - C_NUM_VCS)
                                             : VC_IDX_WIDTH'(w_rr_sum);

`ifdef FLIT_SINK_DRAIN_PKT_ATOMIC_EN
   typedef enum logic [0:0] {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   lock_state_t             state_q, state_d;
   logic [VC_IDX_WIDTH-1:0] lock_vc_q, lock_vc_d;
   logic                    w_pop_tail;

   assign w_pop_tail = pop_tail_ivc[w_gnt_idx];

   // While locked the held VC is the only candidate, even when it is empty
   always_comb begin
      w_gnt_found = w_rr_found;
      w_gnt_idx   = w_rr_idx;
      if (state_q == ST_LOCKED) begin
         w_gnt_found = w_req[lock_vc_q];
         w_gnt_idx   = lock_vc_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_vc_d = lock_vc_q;
      rr_d      = rr_q;
      if (pop_valid) begin
         if (w_pop_tail) begin
            state_d = ST_FREE;
            rr_d    = w_gnt_next;
         end else begin
            state_d   = ST_LOCKED;
            lock_vc_d = w_gnt_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FREE;
         lock_vc_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_vc_q <= lock_vc_d;
      end
   end
`else
   logic w_unused_tail;
   assign w_unused_tail = ^pop_tail_ivc;

   always_comb begin
      w_gnt_found = w_rr_found;
      w_gnt_idx   = w_rr_idx;
   end

   always_comb begin
      rr_d = rr_q;
      if (pop_valid) begin
         rr_d = w_gnt_next;
      end
   end
`endif

   assign w_gnt_next = (w_gnt_idx == C_LAST_VC) ? '0 : w_gnt_idx + VC_IDX_WIDTH'(1);

   always_comb begin
      w_gnt_onehot = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         w_gnt_onehot[v] = (VC_IDX_WIDTH'(v) == w_gnt_idx);
      end
   end

   assign pop_valid   = w_permit & w_gnt_found;
   assign pop_sel_ivc = w_gnt_onehot & {NUM_VCS{pop_valid}};

   // ------------------------------------------------------------------------
   // Occupancy and error tracking; malformed pushes only raise the error
   // ------------------------------------------------------------------------
   assign w_push_onehot = (push_sel_ivc != '0) &&
                          ((push_sel_ivc & (push_sel_ivc - NUM_VCS'(1))) == '0);
   assign w_inc = push_sel_ivc & {NUM_VCS{push_valid & w_push_onehot}};
   assign w_dec = pop_sel_ivc;

   always_comb begin
      error_d = error_q | (push_valid & ~w_push_onehot);
      for (int v = 0; v < NUM_VCS; v++) begin
         occ_d[v] = occ_q[v];
         if (w_inc[v] && !w_dec[v]) begin
            if (occ_q[v] == C_OCC_MAX) begin
               error_d = 1'b1;
            end else begin
               occ_d[v] = occ_q[v] + OCC_W'(1);
            end
         end else if (w_dec[v] && !w_inc[v]) begin
            occ_d[v] = occ_q[v] - OCC_W'(1);
         end
      end
   end

   assign flow_ctrl_d = pop_valid ? {1'b1, w_gnt_idx} : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         rr_q        <= '0;
         flow_ctrl_q <= '0;
         error_q     <= 1'b0;
         for (int v = 0; v < NUM_VCS; v++) begin
            occ_q[v] <= '0;
         end
      end else begin
         acc_q       <= acc_d;
         rr_q        <= rr_d;
         flow_ctrl_q <= flow_ctrl_d;
         error_q     <= error_d;
         for (int v = 0; v < NUM_VCS; v++) begin
            occ_q[v] <= occ_d[v];
         end
      end
   end

   assign flow_ctrl = flow_ctrl_q;
   assign error     = error_q;

endmodule
`default_nettype wire
